ahb_boot_monitor: RTL and testbench

- Synthesizable boot-progress monitor on the AHB-Lite master bus of mipsfpga_sys, downstream of the core.
- Watches address phases for two boot milestones: data-cache-initialised (kseg0 about to become cacheable) and user-code entry.
- Records the cycle count at each milestone and raises a halt request with acknowledge handshake.
- Flags out-of-order or timed-out boot through sticky error outputs.

---
 rtl/ahb_boot_monitor.sv | 180 ++++++++++++++++++
 tb/tb_ahb_boot_monitor.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_boot_monitor.sv
// Boot-progress monitor on the AHB-Lite master bus: tracks the cache-init and
// user-entry milestones, captures cycle counts, raises a halt handshake and
// flags out-of-order or timed-out boot.
// Optional feature macro: BOOTMON_HISTORY_EN (4-entry qualified-address history).
`timescale 1ns/1ps
module ahb_boot_monitor #(
    parameter logic [31:0] CACHE_ADDR     = 32'h1fc00058,
    parameter logic [31:0] USER_ADDR      = 32'h0000075c,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000,
    parameter bit          HALT_ON_EVENT  = 1'b1
) (
    input  logic        SI_ClkIn,
    input  logic        SI_Reset_N,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        halt_ack,
`ifdef BOOTMON_HISTORY_EN
    input  logic [1:0]  hist_sel,
    output logic [31:0] hist_addr,
`endif
    output logic [1:0]  milestone,
    output logic        evt_pulse,
    output logic        halt_req,
    output logic [31:0] cyc_cache,
    output logic [31:0] cyc_user,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_WAIT_USER = 2'd1,
        ST_DONE      = 2'd2,
        ST_ERROR     = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          qual_rd_c;
    logic          hit_cache_c;
    logic          hit_user_c;
    logic          timeout_c;
    logic          evt_nx;
    logic          cap_cache_c;
    logic          cap_user_c;
    logic          err_nx;
    logic [1:0]    code_nx;
    logic          halt_nx;
    logic          unused_htrans0_c;

    // Only NONSEQ/SEQ matters; the IDLE/BUSY distinction in bit 0 is irrelevant
    assign unused_htrans0_c = HTRANS[0];

    assign qual_rd_c   = HTRANS[1] & HREADY & ~HWRITE;
    assign hit_cache_c = qual_rd_c && (HADDR == CACHE_ADDR);
    assign hit_user_c  = qual_rd_c && (HADDR == USER_ADDR);
    assign timeout_c   = (cnt == CW'(TIMEOUT_CYCLES - 32'd1));
    assign milestone   = state;

    // Next-state, capture strobes, error update and halt handshake decode
    always_comb begin
        state_nx    = state;
        evt_nx      = 1'b0;
        cap_cache_c = 1'b0;
        cap_user_c  = 1'b0;
        err_nx      = err;
        code_nx     = err_code;
        unique case (state)
            ST_BOOT: begin
                if (hit_cache_c) begin
                    state_nx    = ST_WAIT_USER;
                    evt_nx      = 1'b1;
                    cap_cache_c = 1'b1;
                end else if (hit_user_c) begin
                    state_nx = ST_ERROR;
                    err_nx   = 1'b1;
                    code_nx  = 2'd1;
                end else if (timeout_c) begin
                    state_nx = ST_ERROR;
                    err_nx   = 1'b1;
                    code_nx  = 2'd2;
                end
            end
            ST_WAIT_USER: begin
                if (hit_user_c) begin
                    state_nx   = ST_DONE;
                    evt_nx     = 1'b1;
                    cap_user_c = 1'b1;
                end else if (timeout_c) begin
                    state_nx = ST_ERROR;
                    err_nx   = 1'b1;
                    code_nx  = 2'd2;
                end
            end
            ST_DONE:  ;
            ST_ERROR: ;
            default:  ;
        endcase
        // A new event re-arms the request even if an ack arrives the same cycle
        halt_nx = halt_req;
        if (HALT_ON_EVENT && evt_nx) begin
            halt_nx = 1'b1;
        end else if (halt_ack) begin
            halt_nx = 1'b0;
        end
    end

    // State register
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nx;
        end
    end

    // Registered outputs: event pulse, halt, captures and sticky error
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            evt_pulse <= 1'b0;
            halt_req  <= 1'b0;
            cyc_cache <= '0;
            cyc_user  <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            evt_pulse <= evt_nx;
            halt_req  <= halt_nx;
            err       <= err_nx;
            err_code  <= code_nx;
            if (cap_cache_c) cyc_cache <= cnt;
            if (cap_user_c)  cyc_user  <= cnt;
        end
    end

    // Saturating boot cycle counter, frozen while halted or after boot ends
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            cnt <= '0;
        end else if ((state == ST_BOOT || state == ST_WAIT_USER) && !halt_req
                     && (cnt != {CW{1'b1}})) begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef BOOTMON_HISTORY_EN
    logic [31:0] hist [4];
    logic [1:0]  wr_ptr;
    logic        frozen;

    // Circular address history; freezes on a transition, thaws when halt clears
    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            hist      <= '{default: '0};
            wr_ptr    <= 2'd0;
            frozen    <= 1'b0;
            hist_addr <= '0;
        end else begin
            if (!frozen && HTRANS[1] && HREADY) begin
                hist[wr_ptr] <= HADDR;
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (state_nx != state) begin
                frozen <= 1'b1;
            end else if (halt_req && !halt_nx) begin
                frozen <= 1'b0;
            end
            hist_addr <= hist[wr_ptr - 2'd1 - hist_sel];
        end
    end
`else
    // History capture not built in this configuration
`endif

endmodule

// File: tb/tb_ahb_boot_monitor.sv
// Self-checking bench for ahb_boot_monitor: directed scenarios plus a random
// run, compared against a milestone-level reference model. Two instances share
// the bus: one with the default timeout, one with a 50-cycle timeout.
`timescale 1ns/1ps
module tb_ahb_boot_monitor;

    localparam logic [31:0] CACHE = 32'h1fc00058;
    localparam logic [31:0] USER  = 32'h0000075c;
    localparam logic [31:0] TO_A  = 32'd2000000;
    localparam logic [31:0] TO_B  = 32'd50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic        hready = 1'b1;
    logic        hack = 1'b0;
    logic [1:0]  hsel = 2'd0;

    logic [1:0]  ms_o   [2];
    logic        evt_o  [2];
    logic        halt_o [2];
    logic [31:0] cc_o   [2];
    logic [31:0] cu_o   [2];
    logic        err_o  [2];
    logic [1:0]  ec_o   [2];
    logic [31:0] hist_o [2];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_phase [2];
    logic [31:0] m_cnt   [2];
    logic [31:0] m_cc    [2];
    logic [31:0] m_cu    [2];
    logic        m_err   [2];
    logic [1:0]  m_code  [2];
    logic        m_evt   [2];
    logic        m_halt  [2];
    logic [31:0] m_hist  [2][4];
    logic        m_frz   [2];
    logic [31:0] m_hout  [2];

    ahb_boot_monitor #(.TIMEOUT_CYCLES(TO_A)) dut_a (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n),
`ifdef BOOTMON_HISTORY_EN
        .hist_sel(hsel), .hist_addr(hist_o[0]),
`endif
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HREADY(hready),
        .halt_ack(hack), .milestone(ms_o[0]), .evt_pulse(evt_o[0]),
        .halt_req(halt_o[0]), .cyc_cache(cc_o[0]), .cyc_user(cu_o[0]),
        .err(err_o[0]), .err_code(ec_o[0])
    );

    ahb_boot_monitor #(.TIMEOUT_CYCLES(TO_B)) dut_b (
        .SI_ClkIn(clk), .SI_Reset_N(rst_n),
`ifdef BOOTMON_HISTORY_EN
        .hist_sel(hsel), .hist_addr(hist_o[1]),
`endif
        .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HREADY(hready),
        .halt_ack(hack), .milestone(ms_o[1]), .evt_pulse(evt_o[1]),
        .halt_req(halt_o[1]), .cyc_cache(cc_o[1]), .cyc_user(cu_o[1]),
        .err(err_o[1]), .err_code(ec_o[1])
    );

    always #5 clk = ~clk;

    // Global bound on simulation time
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = 0;  m_cnt[i] = '0; m_cc[i] = '0; m_cu[i] = '0;
            m_err[i] = 1'b0; m_code[i] = 2'd0; m_evt[i] = 1'b0; m_halt[i] = 1'b0;
            m_frz[i] = 1'b0; m_hout[i] = '0;
            for (int j = 0; j < 4; j++) m_hist[i][j] = '0;
        end
    endfunction

    // One clock of boot-milestone behaviour given the bus values at the edge
    function automatic void model_step(logic [31:0] a, logic [1:0] t, logic w, logic r, logic k);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] lim;
            logic        hc, hu, old_halt;
            int          old_ph;
            logic [31:0] c;
            lim      = (i == 0) ? TO_A : TO_B;
            hc       = t[1] && r && !w && (a == CACHE);
            hu       = t[1] && r && !w && (a == USER);
            old_ph   = m_phase[i];
            old_halt = m_halt[i];
            c        = m_cnt[i];
            m_evt[i] = 1'b0;
            if (old_ph == 0) begin
                if (hc)            begin m_phase[i] = 1; m_cc[i] = c; m_evt[i] = 1'b1; end
                else if (hu)       begin m_phase[i] = 3; m_err[i] = 1'b1; m_code[i] = 2'd1; end
                else if (c == lim - 1) begin m_phase[i] = 3; m_err[i] = 1'b1; m_code[i] = 2'd2; end
            end else if (old_ph == 1) begin
                if (hu)            begin m_phase[i] = 2; m_cu[i] = c; m_evt[i] = 1'b1; end
                else if (c == lim - 1) begin m_phase[i] = 3; m_err[i] = 1'b1; m_code[i] = 2'd2; end
            end
            if (m_evt[i]) m_halt[i] = 1'b1;
            else if (k)   m_halt[i] = 1'b0;
            if (old_ph <= 1 && !old_halt && c != 32'hFFFFFFFF) m_cnt[i] = c + 1;
            m_hout[i] = m_hist[i][hsel];
            if (!m_frz[i] && t[1] && r) begin
                for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = a;
            end
            if (m_phase[i] != old_ph)          m_frz[i] = 1'b1;
            else if (old_halt && !m_halt[i])   m_frz[i] = 1'b0;
        end
    endfunction

    function automatic logic [70:0] exp_vec(int i);
        return {2'(m_phase[i]), m_evt[i], m_halt[i], m_err[i], m_code[i], m_cc[i], m_cu[i]};
    endfunction

    function automatic logic [70:0] act_vec(int i);
        return {ms_o[i], evt_o[i], halt_o[i], err_o[i], ec_o[i], cc_o[i], cu_o[i]};
    endfunction

    task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic w,
                         input logic r, input logic k);
        haddr = a; htrans = t; hwrite = w; hready = r; hack = k;
        @(posedge clk);
        model_step(a, t, w, r, k);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle($urandom, 2'b00, 1'($urandom % 2), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        hack = 1'b0; htrans = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== 71'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d] got %h want 0", i, act_vec(i));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_boot_sequence();
        do_reset();
        idle(20);
        checks++;
        if (ms_o[0] !== 2'd0) begin errors++; $display("FAIL boot_idle_ms got %0d want 0", ms_o[0]); end
        cycle(CACHE, 2'b10, 1'b0, 1'b1, 1'b0);                  // edge 20
        checks++;
        if ({ms_o[0], cc_o[0], evt_o[0], halt_o[0]} !== {2'd1, 32'd20, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL cache_hit ms/cc/evt/halt got %0d/%0d/%b/%b want 1/20/1/1",
                     ms_o[0], cc_o[0], evt_o[0], halt_o[0]);
        end
        cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);                  // edge 21
        checks++;
        if ({evt_o[0], halt_o[0]} !== 2'b01) begin
            errors++; $display("FAIL cache_evt_width evt/halt got %b/%b want 0/1", evt_o[0], halt_o[0]);
        end
        idle(3);                                                 // edges 22..24
        cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b1);                  // ack at edge 25
        checks++;
        if (halt_o[0] !== 1'b0) begin errors++; $display("FAIL halt_clear got %b want 0", halt_o[0]); end
        idle(99);                                                // counter 21..119
        cycle(USER, 2'b11, 1'b0, 1'b1, 1'b0);                   // counter == 120
        checks++;
        if ({ms_o[0], cu_o[0], evt_o[0], halt_o[0]} !== {2'd2, 32'd120, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL user_hit ms/cu/evt/halt got %0d/%0d/%b/%b want 2/120/1/1",
                     ms_o[0], cu_o[0], evt_o[0], halt_o[0]);
        end
        cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++; $display("FAIL boot_model[%0d] got %h want %h", i, act_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_order_error();
        do_reset();
        idle(3 + int'($urandom % 10));
        cycle(USER, 2'b10, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ms_o[0], err_o[0], ec_o[0], evt_o[0], halt_o[0]} !== {2'd3, 1'b1, 2'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL order_err ms/err/code/evt/halt got %0d/%b/%0d/%b/%b want 3/1/1/0/0",
                     ms_o[0], err_o[0], ec_o[0], evt_o[0], halt_o[0]);
        end
        cycle(CACHE, 2'b10, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({ms_o[0], ec_o[0], evt_o[0]} !== {2'd3, 2'd1, 1'b0}) begin
            errors++; $display("FAIL order_sticky ms/code/evt got %0d/%0d/%b want 3/1/0",
                               ms_o[0], ec_o[0], evt_o[0]);
        end
    endtask

    task automatic test_unqualified();
        logic [1:0]  tt [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
        logic        ww [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        rr [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        idle(2);
        for (int v = 0; v < 8; v++) begin
            cycle((v < 4) ? CACHE : USER, tt[v % 4], ww[v % 4], rr[v % 4], 1'b0);
            checks++;
            if ({ms_o[0], evt_o[0], err_o[0]} !== {2'd0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL unqualified_%0d ms/evt/err got %0d/%b/%b want 0/0/0",
                                   v, ms_o[0], evt_o[0], err_o[0]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        idle(49);                                                // counter 0..48
        checks++;
        if (ms_o[1] !== 2'd0) begin errors++; $display("FAIL pre_timeout got %0d want 0", ms_o[1]); end
        idle(1);                                                 // counter == 49
        checks++;
        if ({ms_o[1], err_o[1], ec_o[1], evt_o[1], ms_o[0]} !== {2'd3, 1'b1, 2'd2, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL timeout ms/err/code/evt/ms_a got %0d/%b/%0d/%b/%0d want 3/1/2/0/0",
                     ms_o[1], err_o[1], ec_o[1], evt_o[1], ms_o[0]);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        idle(49);
        cycle(CACHE, 2'b10, 1'b0, 1'b1, 1'b0);                  // hit on the timeout cycle
        checks++;
        if ({ms_o[1], cc_o[1], ec_o[1], evt_o[1]} !== {2'd1, 32'd49, 2'd0, 1'b1}) begin
            errors++; $display("FAIL timeout_race ms/cc/code/evt got %0d/%0d/%0d/%b want 1/49/0/1",
                               ms_o[1], cc_o[1], ec_o[1], evt_o[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        idle(2);
        cycle(CACHE, 2'b10, 1'b0, 1'b1, 1'b0);
        idle(1);
        cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
        cycle(USER, 2'b10, 1'b0, 1'b1, 1'b0);                   // while halt_req still high
        checks++;
        if ({ms_o[0], evt_o[0], halt_o[0], cu_o[0]} !== {2'd2, 1'b1, 1'b1, 32'd3}) begin
            errors++; $display("FAIL b2b_user ms/evt/halt/cu got %0d/%b/%b/%0d want 2/1/1/3",
                               ms_o[0], evt_o[0], halt_o[0], cu_o[0]);
        end
        cycle(32'h0, 2'b00, 1'b0, 1'b1, 1'b1);
        checks++;
        if (halt_o[0] !== 1'b0) begin errors++; $display("FAIL b2b_single_ack got %b want 0", halt_o[0]); end
    endtask

    task automatic test_async_reset_halt();
        do_reset();
        idle(5);
        cycle(CACHE, 2'b10, 1'b0, 1'b1, 1'b0);
        checks++;
        if (halt_o[0] !== 1'b1) begin errors++; $display("FAIL async_pre_halt got %b want 1", halt_o[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_vec(i) !== 71'd0) begin
                errors++; $display("FAIL async_reset[%0d] got %h want 0", i, act_vec(i));
            end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            int          s;
            if ($urandom % 40 == 0) do_reset();
            s = int'($urandom % 8);
            a = (s < 2) ? CACHE : (s < 4) ? USER : $urandom;
            hsel = 2'($urandom);
            cycle(a, 2'($urandom), 1'($urandom % 4 == 0), 1'($urandom % 5 != 0), 1'($urandom % 4 == 0));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL random_%0d[%0d] got %h want %h", n, i, act_vec(i), exp_vec(i));
                end
`ifdef BOOTMON_HISTORY_EN
                checks++;
                if (hist_o[i] !== m_hout[i]) begin
                    errors++; $display("FAIL random_hist_%0d[%0d] got %h want %h", n, i, hist_o[i], m_hout[i]);
                end
`endif
            end
        end
    endtask

`ifdef BOOTMON_HISTORY_EN
    task automatic test_history();
        logic [31:0] exp_h [4] = '{CACHE, 32'hc000_0003, 32'hb000_0002, 32'ha000_0001};
        do_reset();
        cycle(32'ha000_0001, 2'b10, 1'b0, 1'b1, 1'b0);
        cycle(32'hb000_0002, 2'b11, 1'b1, 1'b1, 1'b0);
        cycle(32'hc000_0003, 2'b10, 1'b0, 1'b1, 1'b0);
        cycle(CACHE, 2'b10, 1'b0, 1'b1, 1'b0);
        for (int s = 0; s < 4; s++) begin
            hsel = 2'(s);
            cycle($urandom, 2'b10, 1'b0, 1'b1, 1'b0);          // frozen: not recorded
            checks++;
            if (hist_o[0] !== exp_h[s]) begin
                errors++; $display("FAIL history_sel%0d got %h want %h", s, hist_o[0], exp_h[s]);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_boot_sequence();
        test_order_error();
        test_unqualified();
        test_timeout();
        test_timeout_race();
        test_back_to_back();
        test_async_reset_halt();
`ifdef BOOTMON_HISTORY_EN
        test_history();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
